alu_mdu_ctrl: RTL and testbench
===============================

ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 Parameter XLEN, 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter FAST_DIV0, 1, 1 = divide-by-zero and overflow cases bypass iteration.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  instruction in execute stage is valid.
REQ-006 kill_i  in  1  pipeline flush; aborts any MDU operation.
REQ-007 aluop_i  in  5  opcode[6:2] class: R 01100, I 00100, S 01000, L 00000, B 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101.
REQ-008 f3_i  in  3  funct3.
REQ-009 f7_i  in  7  full funct7.
REQ-010 rs1_i, rs2_i  in  XLEN  MDU operands.
REQ-011 aluoperacion_o  out  4  ALU operation select.
REQ-012 branch_ctrl_o  out  3  branch condition select.
REQ-013 mdu_sel_o  out  1  writeback takes mdu_result_o.
REQ-014 mdu_result_o  out  XLEN  multiply/divide result.
REQ-015 stall_o  out  1  hold PC and pipeline.
REQ-016 illegal_o  out  1  unsupported aluop/funct combination.

Function
REQ-017 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 1001, SRL 1010, SRA 1011, INVALID 1111.
REQ-018 R-type with f7 0000000/0100000 SHALL decode {f7[5],f3} to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; any other combination gives INVALID and illegal_o=1.
REQ-019 I-type SHALL ignore f7 except for f3 001 (requires f7=0000000) and f3 101 (f7[5] selects SRA/SRL); f3 000 is always ADD.
REQ-020 S, L, JAL, JALR, LUI, AUIPC SHALL output ADD.
REQ-021 B-type SHALL output branch_ctrl_o=f3_i with XOR for f3 000/001, SLT for 100/101, SLTU for 110/111; f3 010/011 gives INVALID and illegal_o=1.
REQ-022 Non-branch classes SHALL output branch_ctrl_o=000; unknown aluop gives INVALID and illegal_o=1; decode SHALL be combinational and latch-free.
REQ-023 R-type with f7=0000001 is an M-op: f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-024 FSM states IDLE, BUSY, DONE.
REQ-025 IDLE: valid_i & M-op & !kill_i -> latch operands, clear counter, go BUSY; stall_o=1 combinationally that cycle.
REQ-026 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); stall_o=1; after XLEN steps go DONE.
REQ-027 DONE: stall_o=0, mdu_sel_o=1, mdu_result_o valid; unconditional return to IDLE next cycle, no re-issue.
REQ-028 M-op latency SHALL be XLEN+2 cycles issue-to-DONE, i.e. XLEN+1 stalled cycles.
REQ-029 Signs: operands negated to magnitudes per op signedness; quotient sign = sign(rs1)^sign(rs2), remainder sign = sign(rs1); MULH/MULHSU/MULHU return upper XLEN bits, MUL lower.
REQ-030 Divide by zero: quotient all ones, remainder = rs1; signed overflow (most-negative / -1): quotient = rs1, remainder 0.
REQ-031 With FAST_DIV0=1 cases of REQ-030 SHALL go IDLE->DONE directly (1 stall cycle).
REQ-032 kill_i in any state SHALL force IDLE next cycle with stall_o=0 during the kill cycle; kill_i outranks issue.
REQ-033 Outside DONE, mdu_sel_o=0 and mdu_result_o holds last value.

Reset
REQ-034 rst_i SHALL force IDLE, counter 0, mdu_result_o 0, mdu_sel_o 0, stall_o 0, including mid-operation; combinational decode outputs follow inputs.

Structure
REQ-035 Package alu_pkg SHALL hold aluop class codes, ALU op codes, M-op funct3 codes and the FSM state type.
REQ-036 Datapath in sub-module mdu_iter (operand/partial registers, step logic); decode and FSM in alu_mdu_ctrl.

Verification
REQ-037 R, f7=0100000, f3=000 -> aluoperacion_o=0011; I, f7=0100000, f3=000 -> 0010; B f3=110 -> 0110, branch_ctrl_o=110.
REQ-038 XLEN=32 MUL 7 x -3 -> stall_o high 33 cycles, DONE result 0xFFFFFFEB, mdu_sel_o pulse 1 cycle.
REQ-039 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; DIV -7/2 -> -3; REM -7/2 -> -1.
REQ-040 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each with 1 stall cycle.
REQ-041 kill_i at BUSY step 10 -> IDLE next cycle, stall_o low; rst_i at step 5 -> all outputs reset values next cycle.
REQ-042 aluop 10100 -> aluoperacion_o=1111, illegal_o=1, branch_ctrl_o=000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder and the iterative multiply/divide unit:
// opcode classes, ALU op codes, M-extension funct3 codes and FSM states.
package alu_pkg;

  localparam logic [4:0] CLS_R     = 5'b01100;
  localparam logic [4:0] CLS_I     = 5'b00100;
  localparam logic [4:0] CLS_S     = 5'b01000;
  localparam logic [4:0] CLS_L     = 5'b00000;
  localparam logic [4:0] CLS_B     = 5'b11000;
  localparam logic [4:0] CLS_JAL   = 5'b11011;
  localparam logic [4:0] CLS_JALR  = 5'b11001;
  localparam logic [4:0] CLS_LUI   = 5'b01101;
  localparam logic [4:0] CLS_AUIPC = 5'b00101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0011,
    ALU_XOR     = 4'b0100,
    ALU_SLT     = 4'b0101,
    ALU_SLTU    = 4'b0110,
    ALU_SLL     = 4'b1001,
    ALU_SRL     = 4'b1010,
    ALU_SRA     = 4'b1011,
    ALU_INVALID = 4'b1111
  } alu_op_e;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 multiply/divide datapath: magnitude conversion at load, one
// shift-add or restoring-divide step per cycle, sign fix-up on the way out.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_spec_c,
  output logic [XLEN-1:0] o_spec_res_c,
  output logic [XLEN-1:0] o_res_c
);

  localparam int unsigned W2 = 2 * XLEN;

  logic            w_is_div, w_sel_hi, w_s1_sgn, w_s2_sgn, w_n1, w_n2;
  logic [XLEN-1:0] w_m1, w_m2;
  logic            w_zero, w_ovf;

  logic [W2-1:0]   r_p;
  logic [XLEN-1:0] r_d;
  logic            r_is_div, r_neg_lo, r_neg_hi, r_sel_hi, r_spec;
  logic [XLEN-1:0] r_spec_res;

  logic [XLEN:0]   w_sum, w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [W2-1:0]   w_p_mul, w_p_div, w_p_nxt, w_prod;
  logic [XLEN-1:0] w_q, w_r;

  assign w_is_div = i_op[2];
  assign w_sel_hi = w_is_div ? i_op[1] : (i_op != M_MUL);
  assign w_s1_sgn = (i_op != M_MULHU) && (i_op != M_DIVU) && (i_op != M_REMU);
  assign w_s2_sgn = (i_op == M_MUL) || (i_op == M_MULH) || (i_op == M_DIV) || (i_op == M_REM);
  assign w_n1     = w_s1_sgn & i_rs1[XLEN-1];
  assign w_n2     = w_s2_sgn & i_rs2[XLEN-1];
  assign w_m1     = w_n1 ? (~i_rs1 + XLEN'(1)) : i_rs1;
  assign w_m2     = w_n2 ? (~i_rs2 + XLEN'(1)) : i_rs2;

  // Divide-by-zero and most-negative / -1 have fixed architectural results
  assign w_zero   = (i_rs2 == '0);
  assign w_ovf    = !i_op[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign o_spec_c = w_is_div && (w_zero || w_ovf);

  always_comb begin
    o_spec_res_c = '0;
    if (w_zero) o_spec_res_c = i_op[1] ? i_rs1 : '1;
    else        o_spec_res_c = i_op[1] ? '0 : i_rs1;
  end

  // Multiply: {hi,lo} with multiplier in lo, add-then-shift-right
  assign w_sum   = {1'b0, r_p[W2-1:XLEN]} + (r_p[0] ? {1'b0, r_d} : '0);
  assign w_p_mul = {w_sum, r_p[XLEN-1:1]};

  // Divide: {rem,dividend} shift-left, subtract divisor when it fits
  assign w_rem_sh = {r_p[W2-1:XLEN], r_p[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_d});
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_d;
  assign w_p_div  = w_ge ? {w_diff, r_p[XLEN-2:0], 1'b1}
                         : {w_rem_sh[XLEN-1:0], r_p[XLEN-2:0], 1'b0};

  assign w_p_nxt = r_is_div ? w_p_div : w_p_mul;

  assign w_prod = r_neg_lo ? (~w_p_nxt + W2'(1)) : w_p_nxt;
  assign w_q    = r_neg_lo ? (~w_p_nxt[XLEN-1:0] + XLEN'(1)) : w_p_nxt[XLEN-1:0];
  assign w_r    = r_neg_hi ? (~w_p_nxt[W2-1:XLEN] + XLEN'(1)) : w_p_nxt[W2-1:XLEN];

  // Result as it will stand after the step taken this cycle
  always_comb begin
    o_res_c = '0;
    if (r_spec)        o_res_c = r_spec_res;
    else if (r_is_div) o_res_c = r_sel_hi ? w_r : w_q;
    else               o_res_c = r_sel_hi ? w_prod[W2-1:XLEN] : w_prod[XLEN-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p        <= '0;
      r_d        <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_sel_hi   <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
    end else if (i_start) begin
      r_p        <= {{XLEN{1'b0}}, (w_is_div ? w_m1 : w_m2)};
      r_d        <= w_is_div ? w_m2 : w_m1;
      r_is_div   <= w_is_div;
      r_neg_lo   <= w_n1 ^ w_n2;
      r_neg_hi   <= w_n1;
      r_sel_hi   <= w_sel_hi;
      r_spec     <= o_spec_c;
      r_spec_res <= o_spec_res_c;
    end else if (i_step) begin
      r_p <= w_p_nxt;
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// Execute-stage control: combinational ALU/branch decode plus the FSM that
// sequences the iterative multiply/divide unit and stalls the pipeline.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          FAST_DIV0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            kill_i,
  input  logic [4:0]      aluop_i,
  input  logic [2:0]      f3_i,
  input  logic [6:0]      f7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      aluoperacion_o,
  output logic [2:0]      branch_ctrl_o,
  output logic            mdu_sel_o,
  output logic [XLEN-1:0] mdu_result_o,
  output logic            stall_o,
  output logic            illegal_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  alu_op_e         w_alu_op;
  logic [2:0]      w_branch;
  logic            w_illegal, w_is_mop;

  mdu_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_result;
  logic            w_stall, w_load, w_spec;
  logic [XLEN-1:0] w_spec_res, w_iter_res;

  // Opcode/funct decode
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_branch  = 3'b000;
    w_illegal = 1'b0;
    w_is_mop  = 1'b0;
    case (aluop_i)
      CLS_R: begin
        if (f7_i == F7_MULDIV) begin
          w_is_mop = 1'b1;
        end else if ((f7_i == F7_BASE) || (f7_i == F7_ALT)) begin
          case ({f7_i[5], f3_i})
            4'b0000: w_alu_op = ALU_ADD;
            4'b1000: w_alu_op = ALU_SUB;
            4'b0001: w_alu_op = ALU_SLL;
            4'b0010: w_alu_op = ALU_SLT;
            4'b0011: w_alu_op = ALU_SLTU;
            4'b0100: w_alu_op = ALU_XOR;
            4'b0101: w_alu_op = ALU_SRL;
            4'b1101: w_alu_op = ALU_SRA;
            4'b0110: w_alu_op = ALU_OR;
            4'b0111: w_alu_op = ALU_AND;
            default: begin
              w_alu_op  = ALU_INVALID;
              w_illegal = 1'b1;
            end
          endcase
        end else begin
          w_alu_op  = ALU_INVALID;
          w_illegal = 1'b1;
        end
      end
      CLS_I: begin
        case (f3_i)
          3'b000: w_alu_op = ALU_ADD;
          3'b001: begin
            if (f7_i == F7_BASE) begin
              w_alu_op = ALU_SLL;
            end else begin
              w_alu_op  = ALU_INVALID;
              w_illegal = 1'b1;
            end
          end
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: w_alu_op = f7_i[5] ? ALU_SRA : ALU_SRL;
          3'b110: w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      CLS_S, CLS_L, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: w_alu_op = ALU_ADD;
      CLS_B: begin
        w_branch = f3_i;
        case (f3_i[2:1])
          2'b00: w_alu_op = ALU_XOR;
          2'b10: w_alu_op = ALU_SLT;
          2'b11: w_alu_op = ALU_SLTU;
          default: begin
            w_alu_op  = ALU_INVALID;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        w_alu_op  = ALU_INVALID;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign aluoperacion_o = w_alu_op;
  assign branch_ctrl_o  = w_branch;
  assign illegal_o      = w_illegal;

  // MDU sequencing; kill has priority over issue and completion
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && w_is_mop && !kill_i) begin
          w_load      = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = (FAST_DIV0 && w_spec) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (kill_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stall_o      = w_stall && !rst_i;
  assign mdu_sel_o    = (r_state == S_DONE);
  assign mdu_result_o = r_result;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)                 r_cnt <= '0;
      else if (r_state == S_BUSY) r_cnt <= r_cnt + CNT_W'(1);
      if (w_state_nxt == S_DONE) begin
        r_result <= (r_state == S_IDLE) ? w_spec_res : w_iter_res;
      end
    end
  end

  mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu_iter (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_start      (w_load),
    .i_step       (r_state == S_BUSY),
    .i_op         (f3_i),
    .i_rs1        (rs1_i),
    .i_rs2        (rs2_i),
    .o_spec_c     (w_spec),
    .o_spec_res_c (w_spec_res),
    .o_res_c      (w_iter_res)
  );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: decode table, scoreboarded M-ops,
// kill and reset mid-operation.
module tb_alu_mdu_ctrl;

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_I   = 5'b00100;
  localparam logic [4:0] OP_S   = 5'b01000;
  localparam logic [4:0] OP_B   = 5'b11000;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_LUI = 5'b01101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  aluop = 5'b00000;
  logic [2:0]  f3 = 3'b000;
  logic [6:0]  f7 = 7'b0000000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [3:0]  aluoperacion;
  logic [2:0]  branch_ctrl;
  logic        mdu_sel;
  logic [31:0] mdu_result;
  logic        stall;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] res;
    int          stalls;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  alu_mdu_ctrl #(
    .XLEN      (32),
    .FAST_DIV0 (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid),
    .kill_i         (kill),
    .aluop_i        (aluop),
    .f3_i           (f3),
    .f7_i           (f7),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .aluoperacion_o (aluoperacion),
    .branch_ctrl_o  (branch_ctrl),
    .mdu_sel_o      (mdu_sel),
    .mdu_result_o   (mdu_result),
    .stall_o        (stall),
    .illegal_o      (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic dec_case(input string tag, input logic [4:0] c, input logic [2:0] fn3,
                          input logic [6:0] fn7, input logic [3:0] e_alu,
                          input logic [2:0] e_br, input logic e_ill);
    aluop = c; f3 = fn3; f7 = fn7;
    #1;
    check_eq({tag, "_alu"}, 64'(aluoperacion), 64'(e_alu));
    check_eq({tag, "_br"}, 64'(branch_ctrl), 64'(e_br));
    check_eq({tag, "_ill"}, 64'(illegal), 64'(e_ill));
  endtask

  // Starts and ends at a negative edge
  task automatic run_mop(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    exp_t        e;
    int          nstall;
    bit          seen;
    logic [31:0] held;
    e.res    = mdu_model(op, a, b);
    e.stalls = is_special(op, a, b) ? 1 : 33;
    e.tag    = tag;
    sb_q.push_back(e);
    valid = 1'b1; aluop = OP_R; f7 = 7'b0000001; f3 = op; rs1 = a; rs2 = b;
    #1;
    check_eq({tag, "_issue_stall"}, 64'(stall), 64'd1);
    nstall = 1;
    seen   = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mdu_sel) begin seen = 1'b1; break; end
      if (stall) nstall++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check_eq({e.tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({e.tag, "_result"}, 64'(mdu_result), 64'(e.res));
      check_eq({e.tag, "_stalls"}, 64'(nstall), 64'(e.stalls));
      check_eq({e.tag, "_done_stall"}, 64'(stall), 64'd0);
      held = e.res;
      @(negedge clk);
      check_eq({e.tag, "_sel_pulse"}, 64'(mdu_sel), 64'd0);
      check_eq({e.tag, "_hold"}, 64'(mdu_result), 64'(held));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int          pulses;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check_eq("rst_result", 64'(mdu_result), 64'd0);
    check_eq("rst_sel", 64'(mdu_sel), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    dec_case("r_sub",     OP_R, 3'b000, 7'b0100000, 4'b0011, 3'b000, 1'b0);
    dec_case("i_add_f7",  OP_I, 3'b000, 7'b0100000, 4'b0010, 3'b000, 1'b0);
    dec_case("b_sltu",    OP_B, 3'b110, 7'b0000000, 4'b0110, 3'b110, 1'b0);
    dec_case("bad_op",    5'b10100, 3'b000, 7'b0000000, 4'b1111, 3'b000, 1'b1);
    dec_case("r_srl",     OP_R, 3'b101, 7'b0000000, 4'b1010, 3'b000, 1'b0);
    dec_case("r_sra",     OP_R, 3'b101, 7'b0100000, 4'b1011, 3'b000, 1'b0);
    dec_case("r_bad_alt", OP_R, 3'b001, 7'b0100000, 4'b1111, 3'b000, 1'b1);
    dec_case("r_bad_f7",  OP_R, 3'b000, 7'b0000010, 4'b1111, 3'b000, 1'b1);
    dec_case("r_and",     OP_R, 3'b111, 7'b0000000, 4'b0000, 3'b000, 1'b0);
    dec_case("r_or",      OP_R, 3'b110, 7'b0000000, 4'b0001, 3'b000, 1'b0);
    dec_case("r_slt",     OP_R, 3'b010, 7'b0000000, 4'b0101, 3'b000, 1'b0);
    dec_case("i_sll",     OP_I, 3'b001, 7'b0000000, 4'b1001, 3'b000, 1'b0);
    dec_case("i_sll_bad", OP_I, 3'b001, 7'b0100000, 4'b1111, 3'b000, 1'b1);
    dec_case("i_sra",     OP_I, 3'b101, 7'b0100000, 4'b1011, 3'b000, 1'b0);
    dec_case("i_sltu",    OP_I, 3'b011, 7'b1010101, 4'b0110, 3'b000, 1'b0);
    dec_case("b_bne",     OP_B, 3'b001, 7'b0000000, 4'b0100, 3'b001, 1'b0);
    dec_case("b_bge",     OP_B, 3'b101, 7'b0000000, 4'b0101, 3'b101, 1'b0);
    dec_case("b_bad",     OP_B, 3'b010, 7'b0000000, 4'b1111, 3'b010, 1'b1);
    dec_case("s_add",     OP_S, 3'b010, 7'b0100000, 4'b0010, 3'b000, 1'b0);
    dec_case("lui_add",   OP_LUI, 3'b111, 7'b1111111, 4'b0010, 3'b000, 1'b0);
    dec_case("jalr_add",  OP_JALR, 3'b000, 7'b0000000, 4'b0010, 3'b000, 1'b0);
    @(negedge clk);

    run_mop("mul_7x-3",   3'd0, 32'd7, 32'hFFFF_FFFD);
    run_mop("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mop("mulh_neg",   3'd1, 32'h8000_0000, 32'h0000_0003);
    run_mop("mulhsu",     3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_mop("div_-7/2",   3'd4, 32'hFFFF_FFF9, 32'd2);
    run_mop("rem_-7/2",   3'd6, 32'hFFFF_FFF9, 32'd2);
    run_mop("divu_big",   3'd5, 32'hFFFF_FFF0, 32'd7);
    run_mop("remu",       3'd7, 32'd100, 32'd7);
    run_mop("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mop("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mop("div_neg0",   3'd4, 32'hFFFF_FFF9, 32'd0);
    run_mop("divu_5/0",   3'd5, 32'd5, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      run_mop($sformatf("rand%0d", i), rop, ra, rb);
    end
    run_mop("rem_5/0",    3'd6, 32'd5, 32'd0);

    // Kill at BUSY step 10
    prev = mdu_result;
    valid = 1'b1; aluop = OP_R; f7 = 7'b0000001; f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    check_eq("kill_cycle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    check_eq("kill_next_stall", 64'(stall), 64'd0);
    check_eq("kill_next_sel", 64'(mdu_sel), 64'd0);
    check_eq("kill_hold", 64'(mdu_result), 64'(prev));
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mdu_sel || stall) pulses++;
    end
    check_eq("kill_no_done", 64'(pulses), 64'd0);

    // Kill outranks issue
    valid = 1'b1; kill = 1'b1; f3 = 3'd4; rs1 = 32'd9; rs2 = 32'd2;
    #1;
    check_eq("kill_issue_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    check_eq("kill_issue_idle", 64'(stall), 64'd0);

    // Reset at BUSY step 5
    valid = 1'b1; aluop = OP_R; f7 = 7'b0000001; f3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_result", 64'(mdu_result), 64'd0);
    check_eq("rst_mid_sel", 64'(mdu_sel), 64'd0);
    check_eq("rst_mid_stall", 64'(stall), 64'd0);

    run_mop("mul_after_rst", 3'd0, 32'd12345, 32'd678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
